// File: rtl/john_ring_mon.sv
// Observes a 5-bit Johnson/ring counter: decodes phase, classifies each sample
// against the previous one, tracks lock, wraps and sequence errors.
module john_ring_mon #(
    parameter int W        = 5,
    parameter int LOCK_CNT = 3,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [W-1:0]     q_in,
    input  logic             clr,
    output logic [3:0]       phase,
    output logic             phase_vld,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic             wrap_pulse,
    output logic [CNT_W-1:0] wrap_cnt
);

    typedef enum logic {ACQ, LOCKED} state_t;

    // Returns {legal, phase}. Johnson codes are a low thermometer (phases 0..W)
    // or the inverse of one (phases W+1..2W-1); ring codes are one-hot.
    function automatic logic [4:0] decode(input logic m, input logic [W-1:0] v);
        logic [W:0]   t;
        logic [W-1:0] thr;
        logic [4:0]   r;
        r = 5'b0;
        if (m) begin
            for (int k = 0; k < W; k++) begin
                t = {{W{1'b0}}, 1'b1} << k;
                if (v == t[W-1:0]) r = {1'b1, 4'(k)};
            end
        end else begin
            for (int k = 0; k <= W; k++) begin
                t   = ({{W{1'b0}}, 1'b1} << k) - 1'b1;
                thr = t[W-1:0];
                if (v == thr) r = {1'b1, 4'(k)};
                if (k > 0 && k < W && v == ~thr) r = {1'b1, 4'(W + k)};
            end
        end
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [3:0]       run_q, run_d;
    logic [W-1:0]     prev_q, prev_d;
    logic             mode_q, mode_d;
    logic [3:0]       phase_q, phase_d;
    logic             vld_q, vld_d;
    logic             err_q, err_d;
    logic             wrap_q, wrap_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;

    logic       leg_in, leg_prev, adv, hold, bad, restart;
    logic [3:0] ph_in, ph_prev, last_ph, succ_ph;

    always_comb begin
        {leg_in, ph_in}     = decode(mode, q_in);
        {leg_prev, ph_prev} = decode(mode, prev_q);
        last_ph = mode ? 4'(W - 1) : 4'(2 * W - 1);
        succ_ph = (ph_prev == last_ph) ? 4'd0 : ph_prev + 4'd1;
        adv     = leg_in && leg_prev && (ph_in == succ_ph);
        hold    = leg_in && (q_in == prev_q);
        bad     = !adv && !hold;
        restart = (mode != mode_q);

        state_d    = state_q;
        run_d      = run_q;
        err_d      = 1'b0;
        wrap_d     = 1'b0;
        err_cnt_d  = err_cnt_q;
        wrap_cnt_d = wrap_cnt_q;
        prev_d     = q_in;
        mode_d     = mode;
        vld_d      = leg_in;
        phase_d    = leg_in ? ph_in : phase_q;

        if (restart) begin
            state_d = ACQ;
            run_d   = 4'd0;
        end else begin
            case (state_q)
                ACQ: begin
                    if (adv) begin
                        if ({1'b0, run_q} + 5'd1 == 5'(LOCK_CNT)) begin
                            state_d = LOCKED;
                            run_d   = 4'd0;
                        end else begin
                            run_d = run_q + 4'd1;
                        end
                    end else if (bad) begin
                        run_d = 4'd0;
                    end
                end
                LOCKED: begin
                    if (bad) begin
                        err_d   = 1'b1;
                        state_d = ACQ;
                        run_d   = 4'd0;
                        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
                    end
                end
                default: state_d = ACQ;
            endcase
            // A legal successor of the last phase is necessarily phase 0.
            if (adv && ph_prev == last_ph) begin
                wrap_d = 1'b1;
                if (wrap_cnt_q != '1) wrap_cnt_d = wrap_cnt_q + 1'b1;
            end
        end

        if (clr) begin
            err_cnt_d  = '0;
            wrap_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACQ;
            run_q      <= 4'd0;
            prev_q     <= '0;
            mode_q     <= 1'b0;
            phase_q    <= 4'd0;
            vld_q      <= 1'b0;
            err_q      <= 1'b0;
            wrap_q     <= 1'b0;
            err_cnt_q  <= '0;
            wrap_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            prev_q     <= prev_d;
            mode_q     <= mode_d;
            phase_q    <= phase_d;
            vld_q      <= vld_d;
            err_q      <= err_d;
            wrap_q     <= wrap_d;
            err_cnt_q  <= err_cnt_d;
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign phase      = phase_q;
    assign phase_vld  = vld_q;
    assign locked     = (state_q == LOCKED);
    assign err        = err_q;
    assign err_cnt    = err_cnt_q;
    assign wrap_pulse = wrap_q;
    assign wrap_cnt   = wrap_cnt_q;

endmodule

// File: tb/tb_john_ring_mon.sv
// Scoreboard bench for john_ring_mon: directed walks plus random samples,
// expected outputs from a table-driven behavioural model.
module tb_john_ring_mon;
    localparam int W = 5, LOCK_CNT = 3, CNT_W = 8;

    logic clk = 1'b0;
    logic rst_n, mode, clr;
    logic [W-1:0] q_in;
    logic [3:0] phase;
    logic phase_vld, locked, err, wrap_pulse;
    logic [CNT_W-1:0] err_cnt, wrap_cnt;

    john_ring_mon #(.W(W), .LOCK_CNT(LOCK_CNT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .q_in(q_in), .clr(clr),
        .phase(phase), .phase_vld(phase_vld), .locked(locked), .err(err),
        .err_cnt(err_cnt), .wrap_pulse(wrap_pulse), .wrap_cnt(wrap_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] ph;
        logic       vld;
        logic       lck;
        logic       er;
        logic [7:0] ecnt;
        logic       wr;
        logic [7:0] wcnt;
    } obs_t;

    obs_t exp_q[$];
    int checks = 0;
    int errors = 0;

    int jtab[10] = '{0, 1, 3, 7, 15, 31, 30, 28, 24, 16};

    // model state
    int m_prev, m_mode, m_locked, m_run, m_ecnt, m_wcnt, m_phase, m_vld;

    function automatic int idx(input int m, input int code);
        if (m != 0) begin
            for (int i = 0; i < W; i++) if (code == (1 << i)) return i;
        end else begin
            for (int i = 0; i < 2 * W; i++) if (code == jtab[i]) return i;
        end
        return -1;
    endfunction

    function automatic int code_of(input int m, input int i);
        return (m != 0) ? (1 << i) : jtab[i];
    endfunction

    task automatic model_reset();
        m_prev = 0; m_mode = 0; m_locked = 0; m_run = 0;
        m_ecnt = 0; m_wcnt = 0; m_phase = 0; m_vld = 0;
    endtask

    task automatic step(input int m, input int q, input int c);
        int n, li, lp, e_err, e_wrap;
        bit a, h, b;
        obs_t e;
        @(negedge clk);
        mode = m[0]; q_in = q[W-1:0]; clr = c[0];
        n  = (m != 0) ? W : 2 * W;
        li = idx(m, q);
        lp = idx(m, m_prev);
        a  = (li >= 0) && (lp >= 0) && (li == (lp + 1) % n);
        h  = (li >= 0) && (q == m_prev);
        b  = !a && !h;
        e_err = 0; e_wrap = 0;
        if (m != m_mode) begin
            m_locked = 0; m_run = 0;
        end else begin
            if (m_locked == 0) begin
                if (a) begin
                    m_run++;
                    if (m_run == LOCK_CNT) begin m_locked = 1; m_run = 0; end
                end else if (b) m_run = 0;
            end else if (b) begin
                e_err = 1; m_locked = 0; m_run = 0;
                if (m_ecnt < 255) m_ecnt++;
            end
            if (a && lp == n - 1) begin
                e_wrap = 1;
                if (m_wcnt < 255) m_wcnt++;
            end
        end
        if (c != 0) begin m_ecnt = 0; m_wcnt = 0; end
        if (li >= 0) m_phase = li;
        m_vld = (li >= 0);
        m_prev = q; m_mode = m;
        e.ph = 4'(m_phase); e.vld = m_vld[0]; e.lck = m_locked[0]; e.er = e_err[0];
        e.ecnt = 8'(m_ecnt); e.wr = e_wrap[0]; e.wcnt = 8'(m_wcnt);
        exp_q.push_back(e);
    endtask

    // monitor: every clock after reset is an output beat
    always @(posedge clk) begin
        obs_t e, a;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = {phase, phase_vld, locked, err, err_cnt, wrap_pulse, wrap_cnt};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL out t=%0t: got ph=%0d vld=%0b lck=%0b err=%0b ecnt=%0d wrap=%0b wcnt=%0d; exp ph=%0d vld=%0b lck=%0b err=%0b ecnt=%0d wrap=%0b wcnt=%0d",
                         $time, a.ph, a.vld, a.lck, a.er, a.ecnt, a.wr, a.wcnt,
                         e.ph, e.vld, e.lck, e.er, e.ecnt, e.wr, e.wcnt);
            end
        end
    end

    initial begin
        int cur_mode, r, lp, n, q, c;
        rst_n = 1'b0; mode = 1'b0; q_in = '0; clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // reset-state check before any sample is consumed
        #1;
        checks++;
        if ({phase, phase_vld, locked, err, err_cnt, wrap_pulse, wrap_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_state: got %h exp 0",
                     {phase, phase_vld, locked, err, err_cnt, wrap_pulse, wrap_cnt});
        end

        // Johnson walk, lock, two wraps
        for (int i = 1; i < 10; i++) step(0, jtab[i], 0);
        step(0, 0, 0);
        for (int i = 1; i < 10; i++) step(0, jtab[i], 0);
        step(0, 0, 0);
        // hold while locked
        step(0, 5'b00001, 0); step(0, 5'b00011, 0);
        repeat (4) step(0, 5'b00111, 0);
        step(0, 5'b01111, 0);
        // out-of-order jump, relock, illegal code
        step(0, 5'b11111, 0); step(0, 5'b11000, 0);
        step(0, 5'b10000, 0); step(0, 5'b00000, 0); step(0, 5'b00001, 0);
        step(0, 5'b00011, 0); step(0, 5'b00101, 0); step(0, 5'b00101, 0);
        // ring mode lock and wrap, then mode toggle
        step(1, 1, 0); step(1, 2, 0); step(1, 4, 0); step(1, 8, 0);
        step(1, 16, 0); step(1, 1, 0); step(1, 2, 0);
        step(0, 5'b00011, 0); step(0, 5'b00111, 0);
        // drive err_cnt into saturation
        for (int k = 0; k < 260; k++) begin
            step(0, 5'b00000, 0); step(0, 5'b00001, 0); step(0, 5'b00011, 0);
            step(0, 5'b00111, 0); step(0, 5'b00101, 0);
        end
        // clr coincident with an error
        step(0, 5'b00000, 0); step(0, 5'b00001, 0); step(0, 5'b00011, 0);
        step(0, 5'b00111, 0); step(0, 5'b00101, 1); step(0, 5'b00000, 0);
        // wrap_cnt saturation
        for (int k = 0; k < 260; k++) for (int i = 0; i < 10; i++) step(0, jtab[(i + 1) % 10], 0);

        // asynchronous reset in mid-cycle
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({phase, phase_vld, locked, err, err_cnt, wrap_pulse, wrap_cnt} !== '0) begin
            errors++;
            $display("FAIL async_reset: got %h exp 0",
                     {phase, phase_vld, locked, err, err_cnt, wrap_pulse, wrap_cnt});
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(0, 5'b00001, 0); step(0, 5'b00011, 0); step(0, 5'b00111, 0);

        // randomized traffic
        cur_mode = 0;
        for (int k = 0; k < 3000; k++) begin
            r = $urandom_range(99);
            if (r < 3) cur_mode = 1 - cur_mode;
            n  = (cur_mode != 0) ? W : 2 * W;
            lp = idx(cur_mode, m_prev);
            if (r < 75)      q = (lp >= 0) ? code_of(cur_mode, (lp + 1) % n) : code_of(cur_mode, 0);
            else if (r < 85) q = m_prev;
            else if (r < 93) q = code_of(cur_mode, $urandom_range(n - 1));
            else             q = $urandom_range(31);
            c = ($urandom_range(99) < 2) ? 1 : 0;
            step(cur_mode, q, c);
        end

        @(posedge clk); #2;
        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: got %0d pending exp 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/john_ring_mon.md
Name: john_ring_mon

Overview:
- Monitor stage directly downstream of the 5-bit Johnson/ring counter; consumes its q output every clock.
- Classifies each sample as legal or illegal, checks step order, and decodes the phase index.
- Provides lock status, wrap counting and error counting to the control/debug logic.
- Purely observational; never drives the counter.

Parameters:
- W, 5, counter width; Johnson mode has 2*W phases, ring mode has W phases.
- LOCK_CNT, 3, consecutive legal in-order advances needed to enter LOCKED (range 1..15).
- CNT_W, 8, width of err_cnt and wrap_cnt.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = Johnson sequence, 1 = one-hot ring sequence.
- q_in  input  W  counter state (connects to counter q).
- clr  input  1  synchronous clear of err_cnt and wrap_cnt.
- phase  output  4  decoded phase index of last legal sample.
- phase_vld  output  1  high when the last sample was a legal code.
- locked  output  1  FSM is in LOCKED.
- err  output  1  one-cycle pulse on a sequence error while LOCKED.
- err_cnt  output  CNT_W  saturating count of err pulses.
- wrap_pulse  output  1  one-cycle pulse when the sequence passes the last phase into phase 0.
- wrap_cnt  output  CNT_W  saturating count of wrap_pulse.

Behaviour:
- Reset (rst_n low, asynchronous): phase=0, phase_vld=0, locked=0, err=0, err_cnt=0, wrap_pulse=0, wrap_cnt=0, prev=0, run=0, FSM=ACQ.
- All outputs are registered. Outputs after edge k reflect the q_in value sampled at edge k.
- Johnson legal codes and phases (shift left, bit0 <= ~bit4):
  - 00000=0, 00001=1, 00011=2, 00111=3, 01111=4,
  - 11111=5, 11110=6, 11100=7, 11000=8, 10000=9.
- Ring legal codes and phases (rotate left): 00001=0, 00010=1, 00100=2, 01000=3, 10000=4. Every other code is illegal in ring mode.
- Sample classes, judged against prev (the previous sample):
  - ADV: q_in is legal and is the successor of prev.
  - HOLD: q_in == prev and legal; a stalled or loading counter is not an error.
  - BAD: anything else, including illegal codes and legal out-of-order jumps.
- phase and phase_vld:
  - phase updates only on a legal sample and holds otherwise.
  - phase_vld = legal(q_in).
- prev is loaded with q_in every cycle.
- FSM ACQ:
  - ADV: run+1; when run reaches LOCK_CNT, go to LOCKED and set run=0.
  - BAD: run=0.
  - HOLD: run unchanged.
- FSM LOCKED:
  - ADV or HOLD: stay.
  - BAD: err=1 for one cycle, err_cnt+1, go to ACQ, run=0.
- Wraps: wrap_pulse is asserted on an ADV from the last phase (9 Johnson, 4 ring) to phase 0, in either FSM state; wrap_cnt increments.
- Counters saturate at all-ones and do not roll over.
- clr: err_cnt and wrap_cnt become 0 at that edge. clr takes priority over a simultaneous increment. FSM, phase and prev are unaffected.
- mode change: any cycle where mode differs from the registered mode is treated as a restart.
  - FSM goes to ACQ, run=0, no err, no wrap.
  - prev is loaded normally.
  - The registered mode updates.
- A reset asserted mid-sequence aborts everything immediately. After release, the first sample is judged against prev=0 (Johnson phase 0).
- Widths: phase is sized for 2*W <= 16.

Test Plan:
- Reset release, mode=0, q_in walks 00001, 00011, 00111, 01111 -> phase 1,2,3,4; locked=1 after the 3rd ADV edge; err=0.
- Locked Johnson sequence run through 10000 -> 00000 -> wrap_pulse for exactly one cycle, wrap_cnt=1; two full rotations give wrap_cnt=2.
- Locked, q_in held at 00111 for 4 cycles, then 01111 -> locked stays 1, no err, phase 3 then 4.
- Locked, q_in jumps 00011 -> 01111, or injects illegal 00101 -> err pulse 1 cycle, err_cnt=1, locked=0; phase_vld=0 for 00101 with phase held at its previous value.
- mode=1, ring 00001, 00010, 00100, 01000, 10000, 00001 -> lock then wrap_pulse; toggling mode mid-run -> locked=0, err=0.
- Preload err_cnt to 255 via repeated errors -> stays 255; clr asserted together with an err -> err_cnt=0. rst_n asserted mid-cycle -> all outputs 0 without waiting for a clock edge.
